// File: rtl/poly_voice_mixer_if.sv
// Note-event bus from the MIDI stage into the polyphonic voice mixer.
// Strobe semantics: event_valid_in marks one event in that cycle; there is no
// ready signal, so the consumer accepts an event in every cycle that valid is high.
interface poly_voice_mixer_if #(
  parameter int RATE_WIDTH = 24
);
  logic                  event_valid_in;
  logic                  event_on_in;
  logic [6:0]            event_note_in;
  logic [RATE_WIDTH-1:0] event_rate_in;

  modport master (
    output event_valid_in,
    output event_on_in,
    output event_note_in,
    output event_rate_in
  );

  modport slave (
    input event_valid_in,
    input event_on_in,
    input event_note_in,
    input event_rate_in
  );
endinterface

// File: rtl/poly_voice_mixer.sv
// Polyphonic square-wave voice bank with retrigger / free-voice / oldest-steal
// allocation, mixed into one registered signed sample for the I2S transmitter.
module poly_voice_mixer #(
  parameter int              NUM_VOICES = 4,
  parameter int              WIDTH      = 24,
  parameter int              RATE_WIDTH = 24,
  parameter logic [WIDTH-1:0] AMP       = 24'h1FFFFF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  poly_voice_mixer_if.slave     evt,
  output logic [WIDTH-1:0]      sample_out,
  output logic [NUM_VOICES-1:0] voice_active_out,
  output logic                  voice_stolen_out
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int SUM_W = WIDTH + IDX_W;
  localparam logic signed [SUM_W-1:0] AMP_EXT = {{IDX_W{1'b0}}, AMP};

  // Per-voice state
  logic [NUM_VOICES-1:0] active_q;
  logic [NUM_VOICES-1:0] level_q;
  logic [6:0]            note_q [NUM_VOICES];
  logic [RATE_WIDTH-1:0] rate_q [NUM_VOICES];
  logic [RATE_WIDTH-1:0] cnt_q  [NUM_VOICES];
  logic [7:0]            age_q  [NUM_VOICES];

  // Allocation lookup over the current voice state
  logic             hit_found;
  logic             free_found;
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] old_idx;
  logic [7:0]       old_age;

  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = age_q[0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!hit_found && active_q[i] && (note_q[i] == evt.event_note_in)) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if (!free_found && !active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      // Strict compare keeps the lowest index on equal ages.
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IDX_W'(i);
      end
    end
  end

  logic                  note_on;
  logic                  note_off;
  logic                  do_steal;
  logic [IDX_W-1:0]      on_idx;
  logic [RATE_WIDTH-1:0] rate_clamped;

  assign note_on      = evt.event_valid_in && evt.event_on_in;
  assign note_off     = evt.event_valid_in && !evt.event_on_in && hit_found;
  assign do_steal     = note_on && !hit_found && !free_found;
  assign on_idx       = hit_found  ? hit_idx  :
                        free_found ? free_idx : old_idx;
  assign rate_clamped = (evt.event_rate_in == '0) ? RATE_WIDTH'(1) : evt.event_rate_in;

  // Mixer: full-precision sum, then divide by the voice count so it cannot overflow.
  logic signed [SUM_W-1:0] mix_sum;
  logic [WIDTH-1:0]        mix_sample;
  logic                    unused_mix_lsbs;

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (active_q[i]) begin
        if (level_q[i]) mix_sum = mix_sum + AMP_EXT;
        else            mix_sum = mix_sum - AMP_EXT;
      end
    end
  end

  assign mix_sample      = mix_sum[SUM_W-1:IDX_W];
  assign unused_mix_lsbs = ^mix_sum[IDX_W-1:0];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      active_q         <= '0;
      level_q          <= '0;
      sample_out       <= '0;
      voice_stolen_out <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        rate_q[i] <= '0;
        cnt_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      sample_out       <= mix_sample;
      voice_stolen_out <= do_steal;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (note_on && (on_idx == IDX_W'(i))) begin
          active_q[i] <= 1'b1;
          note_q[i]   <= evt.event_note_in;
          rate_q[i]   <= rate_clamped;
          cnt_q[i]    <= '0;
          level_q[i]  <= 1'b1;
          age_q[i]    <= '0;
        end else begin
          if (note_on && active_q[i] && (age_q[i] != 8'hFF)) begin
            age_q[i] <= age_q[i] + 8'd1;
          end
          if (note_off && (hit_idx == IDX_W'(i))) begin
            active_q[i] <= 1'b0;
            cnt_q[i]    <= '0;
          end else if (active_q[i]) begin
            // Each level lasts exactly rate cycles.
            if (cnt_q[i] == (rate_q[i] - RATE_WIDTH'(1))) begin
              cnt_q[i]   <= '0;
              level_q[i] <= ~level_q[i];
            end else begin
              cnt_q[i] <= cnt_q[i] + RATE_WIDTH'(1);
            end
          end else begin
            cnt_q[i] <= '0;
          end
        end
      end
    end
  end

  assign voice_active_out = active_q;

endmodule

// File: doc/poly_voice_mixer.md
Name: poly_voice_mixer

Overview:
Polyphonic successor to the single-voice note/oscillator path. It accepts decoded note events from the MIDI processing stage and allocates them across NUM_VOICES square-wave voices. Voice allocation covers retrigger, free-voice search and oldest-voice stealing. All active voices are mixed into one signed sample that feeds the I2S transmitter's left and right data.

Parameters:
NUM_VOICES, 4, number of simultaneous voices (power of two, 2..16)
WIDTH, 24, sample width in bits (signed two's complement)
RATE_WIDTH, 24, width of per-voice half-period in clk_in cycles
AMP, 24'h1FFFFF, per-voice square amplitude (positive, < 2^(WIDTH-1))

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  synchronous active-high reset
event_valid_in  input  1  one-cycle strobe: note event present
event_on_in  input  1  1 = note-on, 0 = note-off (velocity-0 note-on already converted to note-off upstream)
event_note_in  input  7  MIDI note number
event_rate_in  input  RATE_WIDTH  half-period in clk_in cycles for the note (note-on only)
sample_out  output  WIDTH  signed mixed sample
voice_active_out  output  NUM_VOICES  bit i = voice i sounding
voice_stolen_out  output  1  one-cycle pulse when a note-on stole a voice

Behaviour:
- Reset is synchronous, active-high, and wins over any same-cycle event. All outputs are 0, all voices are inactive, and all counters and ages are 0.
- Per-voice state: active, note[6:0], rate, cnt[RATE_WIDTH-1:0], level (1 = +AMP), age[7:0].
- There is no backpressure: one event is accepted per cycle whenever event_valid_in is high. State updates at the edge where valid is sampled.
- A rate of 0 is clamped to 1.
- Note-on allocation uses the first rule that matches:
  (a) An active voice holds the same note: retrigger that voice.
  (b) Otherwise, take the lowest-index inactive voice.
  (c) Otherwise, steal the voice with the largest age (ties go to the lowest index) and pulse voice_stolen_out for 1 cycle.
- Effect on the chosen voice: active=1, note, rate, cnt=0, level=1, age=0.
- Effect on every other active voice: age += 1, saturating at 255.
- Note-off: clear active on the voice whose note matches. If no active voice holds that note, ignore the event with no state change.
- Oscillation: each active voice increments cnt every cycle. When cnt == rate-1, cnt returns to 0 and level toggles. Each level therefore lasts exactly rate cycles; the period is 2*rate.
- Inactive voices hold cnt=0 and contribute 0.
- Voice value: active ? (level ? +AMP : -AMP) : 0.
- Mixing:
  - sum = signed sum of all voice values, computed at WIDTH+log2(NUM_VOICES) bits.
  - sample_out <= sum >>> log2(NUM_VOICES), registered; it never overflows.
  - Latency: sample_out reflects the voice state from the previous edge. A note-on sampled at edge k appears on sample_out at edge k+1.
- voice_active_out is a direct copy of the active flags, updated at the same edge as the event.
- Reset mid-note: silence on the cycle after rst_in is sampled; there are no pending events.

Test Plan:
1. Reset: hold rst_in 3 cycles with event_valid_in=1 -> sample_out=0, voice_active_out=0000, voice_stolen_out=0.
2. Single tone (AMP=1000): note-on note 60, rate 4 -> voice_active_out=0001 next edge; sample_out=+250 for 4 cycles, then -250 for 4, repeating.
3. Stealing (AMP=1000): note-ons 60, 62, 64, 65 on consecutive cycles -> active=1111; then note-on 67 -> voice 0 (oldest) takes 67, voice_stolen_out pulses 1 cycle, active stays 1111.
4. Release: after scenario 3, note-off 62 -> active=1101; note-off 99 -> no change; note-on 70 -> lands in voice 1, no steal pulse.
5. Retrigger: note 60 held mid-cycle at level -1, then note-on 60 with rate 8 -> same voice, still one bit active, level +AMP, new half-period 8 cycles.
6. Edge rates: note-on with rate 0 -> voice toggles every cycle (treated as rate 1); rst_in asserted during a note-on -> voice_active_out=0 next edge.
